// File: rtl/truth_table_pkg.sv
// Shared types and row/bit mapping for the truth-table probe and its reference models.
// No logic, no latency, no backpressure.
package truth_table_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_FINISH
    } state_e;

    localparam int         NUM_ROWS = 8;
    localparam logic [2:0] LAST_ROW = 3'(NUM_ROWS - 1);

    // Row i of the sweep lands in code bit (7 - i): row 0 is the MSB.
    function automatic logic [2:0] row_to_bit(input logic [2:0] i);
        return LAST_ROW - i;
    endfunction

endpackage

// File: rtl/settle_counter.sv
// Loadable settle-window counter; tc is high while the count equals SETTLE_CYCLES-2.
// Latency: load/increment visible the cycle after the edge. Backpressure: none (en gates counting).
module settle_counter #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int            CW     = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES - 1) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(SETTLE_CYCLES - 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/truth_table_probe.sv
// Sweeps a 3-input block through all 8 rows and packs its output into an 8-bit code (optional TRUTH_TABLE_PROBE_GLITCH_CHECK_EN).
// Latency: done 8*SETTLE_CYCLES+1 edges after start. Backpressure: start ignored while busy; abort cancels.
module truth_table_probe
    import truth_table_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    input  logic       resp,
    output logic [2:0] stim,
    output logic       busy,
    output logic       done,
    output logic [7:0] code,
    output logic       match,
    output logic       unstable
);

    state_e     state_q, state_d;
    logic [2:0] row_q, row_d;
    logic [2:0] stim_q, stim_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] code_q, code_d;
    logic       match_q, match_d;
    logic [7:0] exp_q, exp_d;
    logic [7:0] shadow_q, shadow_d;
    logic       cnt_load;
    logic       cnt_en;
    logic       cnt_tc;
`ifdef TRUTH_TABLE_PROBE_GLITCH_CHECK_EN
    logic       early_q, early_d;
    logic       sticky_q, sticky_d;
    logic       unstable_q, unstable_d;
`endif

    settle_counter #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_counter (
        .clk  (clk),
        .rst_n(rst_n),
        .load (cnt_load),
        .en   (cnt_en),
        .tc   (cnt_tc)
    );

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        stim_d   = stim_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        code_d   = code_q;
        match_d  = match_q;
        exp_d    = exp_q;
        shadow_d = shadow_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
`ifdef TRUTH_TABLE_PROBE_GLITCH_CHECK_EN
        early_d    = early_q;
        sticky_d   = sticky_q;
        unstable_d = unstable_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    exp_d    = expected;
                    row_d    = '0;
                    stim_d   = '0;
                    busy_d   = 1'b1;
                    shadow_d = '0;
                    cnt_load = 1'b1;
                    state_d  = ST_SETTLE;
`ifdef TRUTH_TABLE_PROBE_GLITCH_CHECK_EN
                    sticky_d = 1'b0;
`endif
                end
            end
            ST_SETTLE: begin
                if (cnt_tc) begin
                    state_d = ST_SAMPLE;
`ifdef TRUTH_TABLE_PROBE_GLITCH_CHECK_EN
                    early_d = resp;
`endif
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_SAMPLE: begin
                shadow_d[row_to_bit(row_q)] = resp;
`ifdef TRUTH_TABLE_PROBE_GLITCH_CHECK_EN
                sticky_d = sticky_q | (resp != early_q);
`endif
                if (row_q == LAST_ROW) begin
                    // Publish on this edge so done/code/match are registered in the FINISH cycle.
                    code_d  = shadow_d;
                    match_d = (shadow_d == exp_q);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    stim_d  = '0;
                    state_d = ST_FINISH;
`ifdef TRUTH_TABLE_PROBE_GLITCH_CHECK_EN
                    unstable_d = sticky_d;
`endif
                end else begin
                    row_d    = row_q + 3'd1;
                    stim_d   = row_q + 3'd1;
                    cnt_load = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over everything, including the final SAMPLE publish.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            stim_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            code_d  = code_q;
            match_d = match_q;
`ifdef TRUTH_TABLE_PROBE_GLITCH_CHECK_EN
            unstable_d = unstable_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            stim_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            code_q   <= '0;
            match_q  <= 1'b0;
            exp_q    <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            stim_q   <= stim_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            code_q   <= code_d;
            match_q  <= match_d;
            exp_q    <= exp_d;
            shadow_q <= shadow_d;
        end
    end

`ifdef TRUTH_TABLE_PROBE_GLITCH_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            early_q    <= 1'b0;
            sticky_q   <= 1'b0;
            unstable_q <= 1'b0;
        end else begin
            early_q    <= early_d;
            sticky_q   <= sticky_d;
            unstable_q <= unstable_d;
        end
    end

    assign unstable = unstable_q;
`else
    assign unstable = 1'b0;
`endif

    assign stim  = stim_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign code  = code_q;
    assign match = match_q;

endmodule

// File: tb/tb_truth_table_probe.sv
// Self-checking bench for truth_table_probe: scoreboarded sweeps, abort, ignored starts, glitch flag, async reset.
module tb_truth_table_probe;
    import truth_table_pkg::*;

    localparam int SETTLE = 4;
    localparam int SWEEP  = NUM_ROWS * SETTLE;

    typedef struct packed {
        logic [7:0] code;
        logic       match;
        logic       unst;
    } exp_t;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic       abort    = 1'b0;
    logic [7:0] expected = 8'h00;
    logic       resp;
    logic [2:0] stim;
    logic       busy;
    logic       done;
    logic [7:0] code;
    logic       match;
    logic       unstable;

    int   mode     = 0;   // 0: 0x86 model, 1: tied 1, 2: tied 0
    logic glitch   = 1'b0;
    int   errors   = 0;
    int   checks   = 0;
    int   edge_cnt = 0;
    int   done_cnt = 0;
    int   t_start  = 0;
    exp_t sb_q[$];

`ifdef TRUTH_TABLE_PROBE_GLITCH_CHECK_EN
    localparam logic GLITCH_SEEN = 1'b1;
`else
    localparam logic GLITCH_SEEN = 1'b0;
`endif

    truth_table_probe #(
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .expected(expected),
        .resp    (resp),
        .stim    (stim),
        .busy    (busy),
        .done    (done),
        .code    (code),
        .match   (match),
        .unstable(unstable)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;
    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    // out = ~in1&~in2&~in3 | in1&(in2^in3), with stim[2]=in1, stim[1]=in2, stim[0]=in3
    function automatic logic f86(input logic [2:0] s);
        return (~s[2] & ~s[1] & ~s[0]) | (s[2] & (s[1] ^ s[0]));
    endfunction

    function automatic logic model_out(input int m, input logic [2:0] s);
        case (m)
            1:       return 1'b1;
            2:       return 1'b0;
            default: return f86(s);
        endcase
    endfunction

    always_comb resp = model_out(mode, stim) ^ glitch;

    function automatic logic [7:0] ref_code(input int m);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < NUM_ROWS; i++) c[row_to_bit(3'(i))] = model_out(m, 3'(i));
        return c;
    endfunction

    task automatic push_exp(input int m, input logic [7:0] expv, input logic unst);
        exp_t e;
        e.code  = ref_code(m);
        e.match = (e.code == expv);
        e.unst  = unst;
        sb_q.push_back(e);
    endtask

    task automatic kick(input logic [7:0] expv);
        @(negedge clk);
        start    = 1'b1;
        expected = expv;
        @(negedge clk);
        start   = 1'b0;
        t_start = edge_cnt;
    endtask

    // Entered on the negedge right after start acceptance; walks the sweep and checks the done cycle.
    task automatic finish_sweep(input string name, input int mid_pulse, input bit pulse_on_done);
        exp_t e;
        int   k;
        int   bad;
        bad = 0;
        for (k = 0; k < SWEEP + 20 && done !== 1'b1; k++) begin
            if (stim !== 3'(k / SETTLE)) bad++;
            start = (k == mid_pulse);
            if (k == mid_pulse) expected = 8'h00;
            @(negedge clk);
        end
        start = 1'b0;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        else e = '0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_timeout: done=%b after %0d cycles, required 1", name, done, k);
        end
        checks++;
        if (edge_cnt - t_start != SWEEP) begin
            errors++;
            $display("FAIL %s_latency: %0d edges after start, required %0d", name, edge_cnt - t_start + 1, SWEEP + 1);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_stim_seq: %0d bad stim cycles, required 0", name, bad);
        end
        checks++;
        if (code !== e.code) begin
            errors++;
            $display("FAIL %s_code: got %h required %h", name, code, e.code);
        end
        checks++;
        if (match !== e.match) begin
            errors++;
            $display("FAIL %s_match: got %b required %b", name, match, e.match);
        end
        checks++;
        if (unstable !== e.unst) begin
            errors++;
            $display("FAIL %s_unstable: got %b required %b", name, unstable, e.unst);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_at_done: got %b required 0", name, busy);
        end
        if (pulse_on_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({done, busy, stim} !== 5'b0) begin
            errors++;
            $display("FAIL %s_after_done: done/busy/stim=%b/%b/%0d required 0/0/0", name, done, busy, stim);
        end
        checks++;
        if (code !== e.code) begin
            errors++;
            $display("FAIL %s_code_hold: got %h required %h", name, code, e.code);
        end
    endtask

    task automatic test_reset();
        start = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({stim, busy, done, code, match, unstable} !== 14'b0) begin
            errors++;
            $display("FAIL reset_outputs: stim=%0d busy=%b done=%b code=%h match=%b unstable=%b required all 0",
                     stim, busy, done, code, match, unstable);
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b required 0/0", busy, done);
        end
    endtask

    task automatic test_model();
        mode = 0;
        push_exp(0, 8'h86, 1'b0);
        kick(8'h86);
        finish_sweep("model_86", -1, 1'b0);
        push_exp(0, 8'h96, 1'b0);
        kick(8'h96);
        finish_sweep("model_96", -1, 1'b0);
    endtask

    task automatic test_const();
        mode = 1;
        push_exp(1, 8'hFF, 1'b0);
        kick(8'hFF);
        finish_sweep("tied1", -1, 1'b0);
        mode = 2;
        push_exp(2, 8'h5A, 1'b0);
        kick(8'h5A);
        finish_sweep("tied0", -1, 1'b0);
    endtask

    task automatic test_abort();
        int dc0;
        int n;
        mode = 0;
        push_exp(0, 8'h86, 1'b0);
        kick(8'h86);
        finish_sweep("pre_abort", -1, 1'b0);
        mode = 1;
        kick(8'hFF);
        for (n = 0; n < SWEEP && stim !== 3'd5; n++) @(negedge clk);
        @(negedge clk);
        dc0   = done_cnt;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({stim, busy, done} !== 5'b0) begin
            errors++;
            $display("FAIL abort_outputs: stim=%0d busy=%b done=%b required 0/0/0", stim, busy, done);
        end
        checks++;
        if ({code, match} !== {8'h86, 1'b1}) begin
            errors++;
            $display("FAIL abort_hold: code=%h match=%b required 86/1", code, match);
        end
        repeat (SWEEP + 8) @(negedge clk);
        checks++;
        if (done_cnt != dc0) begin
            errors++;
            $display("FAIL abort_no_done: %0d done pulses, required 0", done_cnt - dc0);
        end
        mode = 0;
        push_exp(0, 8'h86, 1'b0);
        kick(8'h86);
        finish_sweep("post_abort", -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int dc0;
        dc0  = done_cnt;
        mode = 0;
        push_exp(0, 8'h86, 1'b0);
        kick(8'h86);
        finish_sweep("busy_start", 10, 1'b1);
        mode = 2;
        push_exp(2, 8'h00, 1'b0);
        kick(8'h00);
        finish_sweep("next_start", -1, 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt - dc0 != 2) begin
            errors++;
            $display("FAIL single_done: %0d done pulses for 2 accepted starts, required 2", done_cnt - dc0);
        end
    endtask

    task automatic test_glitch();
        mode = 0;
        push_exp(0, 8'h86, GLITCH_SEEN);
        kick(8'h86);
        fork
            finish_sweep("glitch_row3", -1, 1'b0);
            begin
                for (int n = 0; n < SWEEP && stim !== 3'd3; n++) @(negedge clk);
                repeat (SETTLE - 2) @(negedge clk);
                glitch = 1'b1;
                @(negedge clk);
                glitch = 1'b0;
            end
        join
        push_exp(0, 8'h86, 1'b0);
        kick(8'h86);
        finish_sweep("clean_after_glitch", -1, 1'b0);
    endtask

    task automatic test_async_reset();
        int dc0;
        mode = 1;
        kick(8'hFF);
        repeat (10) @(negedge clk);
        dc0 = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({stim, busy, done, code, match} !== 13'b0) begin
            errors++;
            $display("FAIL async_reset: stim=%0d busy=%b done=%b code=%h match=%b required all 0",
                     stim, busy, done, code, match);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (SWEEP + 8) @(negedge clk);
        checks++;
        if (done_cnt != dc0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_no_done: %0d done pulses busy=%b, required 0 and 0", done_cnt - dc0, busy);
        end
    endtask

    initial begin
        test_reset();
        test_model();
        test_const();
        test_abort();
        test_back_to_back();
        test_glitch();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
